// File: rtl/pc_gen.sv
// Fetch program-counter generator for the IF stage: holds the fetch PC, issues
// req/addr_ok fetch requests and arbitrates exception > eret > branch > sequential.
module pc_gen #(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'hbfc00000,
    parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380,
    parameter int          FETCH_WIDTH  = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             stallF,
    input  logic             exc_flush,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             inst_addr_ok,
    output logic             inst_req,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic             ce,
    output logic             pc_adel,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] INC = WIDTH'(4 * FETCH_WIDTH);

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] pend_target;
    logic [WIDTH-1:0] pend_d;
    logic             advance;

    // Handshake: a fetch transfers on a cycle where inst_req and inst_addr_ok are
    // both high; inst_req never depends on inst_addr_ok.
    assign inst_req  = ce & ~stallF;
    assign advance   = inst_req & inst_addr_ok;
    assign pc_adel   = |pc[1:0];
    assign dbg_state = state;

    always_comb begin
        pc_next = pc;
        state_d = state;
        pend_d  = pend_target;
        if (state == BOOT) begin
            state_d = RUN;
        end else if (exc_flush) begin
            pc_next = WIDTH'(EXC_VECTOR);
            state_d = RUN;
        end else if (eret) begin
            pc_next = epc;
            state_d = RUN;
        end else if (branch_taken && advance) begin
            pc_next = branch_target;
            state_d = RUN;
        end else if (branch_taken) begin
            // Fetch cannot move this cycle; remember the newest target instead.
            pend_d  = branch_target;
            state_d = PEND;
        end else if (state == PEND && advance) begin
            pc_next = pend_target;
            state_d = RUN;
        end else if (advance) begin
            pc_next = pc + INC;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc          <= WIDTH'(RESET_VECTOR);
            ce          <= 1'b0;
            state       <= BOOT;
            pend_target <= '0;
        end else begin
            pc          <= pc_next;
            ce          <= 1'b1;
            state       <= state_d;
            pend_target <= pend_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: vector table on a FETCH_WIDTH=1 instance, plus hand
// sequences for async reset mid-PEND and FETCH_WIDTH=2 wrap.
module tb_pc_gen;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;

    typedef struct {
        logic        stall;
        logic        exc;
        logic        er;
        logic [31:0] epc;
        logic        br;
        logic [31:0] tgt;
        logic        ok;
        logic        exp_req;
        logic [31:0] exp_pc;
        logic [1:0]  exp_state;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stallF = 1'b0;
    logic        exc_flush = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        inst_addr_ok = 1'b0;

    logic        req1, ce1, adel1;
    logic [31:0] pc1, pcn1;
    logic [1:0]  st1;
    logic        req2, ce2, adel2;
    logic [31:0] pc2, pcn2;
    logic [1:0]  st2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_gen #(.FETCH_WIDTH(1)) u1 (
        .clk(clk), .resetn(resetn), .stallF(stallF), .exc_flush(exc_flush),
        .eret(eret), .epc(epc), .branch_taken(branch_taken),
        .branch_target(branch_target), .inst_addr_ok(inst_addr_ok),
        .inst_req(req1), .pc(pc1), .pc_next(pcn1), .ce(ce1), .pc_adel(adel1),
        .dbg_state(st1)
    );

    pc_gen #(.FETCH_WIDTH(2)) u2 (
        .clk(clk), .resetn(resetn), .stallF(stallF), .exc_flush(exc_flush),
        .eret(eret), .epc(epc), .branch_taken(branch_taken),
        .branch_target(branch_target), .inst_addr_ok(inst_addr_ok),
        .inst_req(req2), .pc(pc2), .pc_next(pcn2), .ce(ce2), .pc_adel(adel2),
        .dbg_state(st2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic stall, input logic exc, input logic er,
                                input logic [31:0] e, input logic br, input logic [31:0] t,
                                input logic ok, input logic req, input logic [31:0] p,
                                input logic [1:0] s);
        vec_t v;
        v.stall = stall; v.exc = exc; v.er = er; v.epc = e; v.br = br; v.tgt = t;
        v.ok = ok; v.exp_req = req; v.exp_pc = p; v.exp_state = s;
        return v;
    endfunction

    // Entered right after a negedge; drives, checks combinational outputs, then the
    // registered ones one edge later, and returns aligned at the next negedge.
    task automatic step(input vec_t v, input bit use_u2, input string tag);
        logic [31:0] pcn, pcv;
        logic        req, ce, adel;
        logic [1:0]  st;
        stallF = v.stall; exc_flush = v.exc; eret = v.er; epc = v.epc;
        branch_taken = v.br; branch_target = v.tgt; inst_addr_ok = v.ok;
        #1;
        req = use_u2 ? req2 : req1;
        pcn = use_u2 ? pcn2 : pcn1;
        check({tag, " inst_req"}, {31'b0, req}, {31'b0, v.exp_req});
        check({tag, " pc_next"}, pcn, v.exp_pc);
        @(posedge clk);
        #1;
        pcv  = use_u2 ? pc2 : pc1;
        st   = use_u2 ? st2 : st1;
        ce   = use_u2 ? ce2 : ce1;
        adel = use_u2 ? adel2 : adel1;
        check({tag, " pc"}, pcv, v.exp_pc);
        check({tag, " state"}, {30'b0, st}, {30'b0, v.exp_state});
        check({tag, " ce"}, {31'b0, ce}, 32'd1);
        check({tag, " pc_adel"}, {31'b0, adel}, {31'b0, v.exp_pc[1:0] != 2'b00});
        @(negedge clk);
    endtask

    vec_t tbl[26];
    vec_t seq2[5];

    initial begin
        tbl[0]  = mk(0,0,0,32'h0,0,32'h0,1, 0,32'hbfc00000,S_RUN);
        tbl[1]  = mk(0,0,0,32'h0,0,32'h0,1, 1,32'hbfc00004,S_RUN);
        tbl[2]  = mk(0,0,0,32'h0,0,32'h0,0, 1,32'hbfc00004,S_RUN);
        tbl[3]  = mk(0,0,0,32'h0,0,32'h0,0, 1,32'hbfc00004,S_RUN);
        tbl[4]  = mk(0,0,0,32'h0,0,32'h0,0, 1,32'hbfc00004,S_RUN);
        tbl[5]  = mk(0,0,0,32'h0,0,32'h0,1, 1,32'hbfc00008,S_RUN);
        tbl[6]  = mk(1,0,0,32'h0,0,32'h0,1, 0,32'hbfc00008,S_RUN);
        tbl[7]  = mk(0,0,0,32'h0,1,32'h80001000,0, 1,32'hbfc00008,S_PEND);
        tbl[8]  = mk(0,0,0,32'h0,0,32'h0,0, 1,32'hbfc00008,S_PEND);
        tbl[9]  = mk(0,0,0,32'h0,0,32'h0,0, 1,32'hbfc00008,S_PEND);
        tbl[10] = mk(0,0,0,32'h0,0,32'h0,1, 1,32'h80001000,S_RUN);
        tbl[11] = mk(0,0,0,32'h0,0,32'h0,1, 1,32'h80001004,S_RUN);
        tbl[12] = mk(0,0,0,32'h0,1,32'h80003000,0, 1,32'h80001004,S_PEND);
        tbl[13] = mk(0,0,0,32'h0,1,32'h80004000,0, 1,32'h80001004,S_PEND);
        tbl[14] = mk(0,0,0,32'h0,0,32'h0,1, 1,32'h80004000,S_RUN);
        tbl[15] = mk(0,0,0,32'h0,1,32'h80005000,0, 1,32'h80004000,S_PEND);
        tbl[16] = mk(1,1,1,32'h80002000,1,32'h80006000,1, 0,32'hbfc00380,S_RUN);
        tbl[17] = mk(0,0,0,32'h0,0,32'h0,1, 1,32'hbfc00384,S_RUN);
        tbl[18] = mk(0,0,1,32'h80002000,1,32'h80007000,1, 1,32'h80002000,S_RUN);
        tbl[19] = mk(0,0,0,32'h0,0,32'h0,1, 1,32'h80002004,S_RUN);
        tbl[20] = mk(1,0,1,32'h80008000,0,32'h0,0, 0,32'h80008000,S_RUN);
        tbl[21] = mk(0,0,0,32'h0,1,32'h80000002,1, 1,32'h80000002,S_RUN);
        tbl[22] = mk(0,0,0,32'h0,0,32'h0,1, 1,32'h80000006,S_RUN);
        tbl[23] = mk(0,0,0,32'h0,1,32'hfffffffc,1, 1,32'hfffffffc,S_RUN);
        tbl[24] = mk(0,0,0,32'h0,0,32'h0,1, 1,32'h00000000,S_RUN);
        tbl[25] = mk(0,0,0,32'h0,0,32'h0,1, 1,32'h00000004,S_RUN);

        seq2[0] = mk(0,0,0,32'h0,0,32'h0,1, 0,32'hbfc00000,S_RUN);
        seq2[1] = mk(0,0,0,32'h0,0,32'h0,1, 1,32'hbfc00008,S_RUN);
        seq2[2] = mk(0,0,0,32'h0,1,32'hfffffff8,1, 1,32'hfffffff8,S_RUN);
        seq2[3] = mk(0,0,0,32'h0,0,32'h0,1, 1,32'h00000000,S_RUN);
        seq2[4] = mk(0,0,0,32'h0,0,32'h0,1, 1,32'h00000008,S_RUN);

        inst_addr_ok = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset pc", pc1, 32'hbfc00000);
        check("reset ce", {31'b0, ce1}, 32'd0);
        check("reset inst_req", {31'b0, req1}, 32'd0);
        check("reset pc_adel", {31'b0, adel1}, 32'd0);
        check("reset state", {30'b0, st1}, {30'b0, S_BOOT});
        resetn = 1'b1;

        for (int i = 0; i < 26; i++) step(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // Enter PEND, then pull reset between edges.
        step(mk(0,0,0,32'h0,1,32'h80009000,0, 1,32'h00000004,S_PEND), 1'b0, "pre_rst");
        #2 resetn = 1'b0;
        #1;
        check("async_rst pc", pc1, 32'hbfc00000);
        check("async_rst ce", {31'b0, ce1}, 32'd0);
        check("async_rst inst_req", {31'b0, req1}, 32'd0);
        check("async_rst state", {30'b0, st1}, {30'b0, S_BOOT});
        @(negedge clk);
        resetn = 1'b1;
        step(mk(0,0,0,32'h0,0,32'h0,1, 0,32'hbfc00000,S_RUN), 1'b0, "post_rst boot");
        step(mk(0,0,0,32'h0,0,32'h0,1, 1,32'hbfc00004,S_RUN), 1'b0, "post_rst seq");

        // FETCH_WIDTH=2 instance from a fresh reset.
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) step(seq2[i], 1'b1, $sformatf("fw2_%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
